rr_req_queue: RTL and testbench
===============================

# rr_req_queue

Request-side queueing stage that sits directly upstream of the 4-requester round-robin arbiter. It buffers transactions from four independent sources in per-source FIFOs, drives the arbiter's `req[3:0]` from FIFO occupancy, consumes the arbiter's one-hot `gnt[3:0]` in the same cycle, and forwards the granted head entry into a single registered valid/ready output channel tagged with its source index.

## Interface
- `DATA_W`, default 8: payload width per entry.
- `DEPTH`, default 4: entries per source FIFO. Must be a power of two and at least 2.
- `CNT_W`, derived as `$clog2(DEPTH+1)`: occupancy counter width. Not overridable.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  4  per-source push request.
- `in_data`  in  4*DATA_W  per-source payload; source i occupies bits `[i*DATA_W +: DATA_W]`.
- `in_ready`  out  4  per-source FIFO not full.
- `req`  out  4  request vector to the arbiter.
- `gnt`  in  4  grant from the arbiter; combinational from `req`, expected one-hot or zero.
- `out_valid`  out  1  output register holds a transaction.
- `out_data`  out  DATA_W  granted payload.
- `out_src`  out  2  source index of `out_data`.
- `out_ready`  in  1  downstream accepts the output.
- `err`  out  1  sticky protocol-violation flag.

## Operation
- Each source has a circular FIFO: storage `DEPTH x DATA_W`, read and write pointers of `$clog2(DEPTH)` bits that wrap naturally, and a `CNT_W`-bit count.
- Push rule: `in_ready[i] = (count[i] != DEPTH)`. A push happens when `in_valid[i] && in_ready[i]`.
  - `in_ready` does not account for a pop in the same cycle, so a full FIFO never accepts a push, even while it is being popped.
- Output register can accept when `acc = !out_valid || out_ready`.
- `req[i] = (count[i] != 0) && acc`.
  - Masking `req` with `acc` is mandatory. The arbiter advances its pointer on every nonzero grant, so every grant it issues must be consumed.
  - This creates a combinational path `out_ready` -> `req` -> `gnt`.
- A grant is valid when `gnt` is one-hot and `gnt & req == gnt`. On a valid grant to source k:
  - pop FIFO k: advance its read pointer and decrement its count;
  - load `out_data` with FIFO k's head entry;
  - set `out_src` to k and `out_valid` to 1.
- A simultaneous push and pop on the same FIFO leaves its count unchanged and updates both pointers.
- If `out_ready` is high and no valid grant occurs, `out_valid` clears. `out_data` and `out_src` hold their last values.
- If `gnt` is nonzero but not a valid grant (multi-hot, or grants a non-requesting source):
  - no pop occurs and the output register is unchanged;
  - `err` is set and stays at 1 until reset.
- There is no bypass. An entry pushed into an empty FIFO is first visible on `req` the following cycle.

## Timing
- Reset values:
  - all counts and pointers 0;
  - `out_valid` 0, `out_data` 0, `out_src` 0, `err` 0;
  - `req` 0, since all FIFOs are empty;
  - `in_ready` 4'b1111, since it is combinational from count.
- Storage contents are not reset.
- Reset asserted mid-operation immediately empties every FIFO and drops `out_valid`. Queued data is lost.
- Latency:
  - push at edge t makes `req` high in cycle t+1;
  - a grant in cycle t+1 makes `out_valid` high in cycle t+2;
  - minimum input-to-output latency is 2 cycles.
- Throughput: one transaction per cycle while `out_ready` stays high.
- Output channel follows standard valid/ready rules: while `out_valid && !out_ready`, `out_data` and `out_src` are held stable and `req` is 0.

## Test plan
- **Single source.** Reset, then push 0xA5 on source 2 at cycle 1.
  - Required: `req`=4'b0100 in cycle 2; `out_valid`=1, `out_data`=0xA5, `out_src`=2 in cycle 3; `in_ready` stays 4'b1111 throughout.
- **Fairness.** Fill all four FIFOs with 0x10+i, hold `out_ready`=1, connect the real arbiter.
  - Required: `out_src` sequence 0,1,2,3,0,1,2,3 on consecutive cycles; data 0x10,0x11,0x12,0x13 repeating.
- **Full boundary.** Push 5 entries to source 0 with `out_ready`=0.
  - Required: `in_ready[0]` drops after the 4th push and the 5th is not accepted.
  - Required: after one output is accepted, the FIFO drains in order with pointer wrap-around intact, and the 5th value is never output.
- **Backpressure.** Hold `out_ready`=0 with `out_valid`=1 for 3 cycles.
  - Required: `req`=0, `out_data` and `out_src` unchanged, no FIFO count decrements.
- **Protocol error.** Force `gnt`=4'b0011, or `gnt`=4'b0001 while `req[0]`=0.
  - Required: `err`=1 from the next cycle, no pop, output unchanged; `err` stays 1 until `rst_n` is asserted.
- **Mid-operation reset.** Assert `rst_n`=0 with all FIFOs holding 2 entries and `out_valid`=1.
  - Required: `out_valid`, `req` and `err` are 0 immediately (asynchronously), and nothing is output after release.

Source files
------------

// File: rtl/rr_req_queue_if.sv
// Handshake bundle between the four request sources, the round-robin arbiter
// and the single tagged output channel of rr_req_queue.
interface rr_req_queue_if #(
  parameter int DATA_W = 8
) ();
  logic [3:0]          in_valid;
  logic [4*DATA_W-1:0] in_data;
  logic [3:0]          in_ready;
  logic [3:0]          req;
  logic [3:0]          gnt;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          out_src;
  logic                out_ready;
  logic                err;

  modport master (
    output in_valid, in_data, gnt, out_ready,
    input  in_ready, req, out_valid, out_data, out_src, err
  );

  modport slave (
    input  in_valid, in_data, gnt, out_ready,
    output in_ready, req, out_valid, out_data, out_src, err
  );
endinterface

// File: rtl/rr_req_queue.sv
// Four per-source FIFOs feeding an external round-robin arbiter; the granted
// head entry lands in a registered valid/ready output tagged with its source.
module rr_req_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_req_queue_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [4][DEPTH];

  logic [CNT_W-1:0]  cnt_q    [4];
  logic [CNT_W-1:0]  cnt_d    [4];
  logic [PTR_W-1:0]  rd_ptr_q [4];
  logic [PTR_W-1:0]  rd_ptr_d [4];
  logic [PTR_W-1:0]  wr_ptr_q [4];
  logic [PTR_W-1:0]  wr_ptr_d [4];

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [1:0]        out_src_q,   out_src_d;
  logic              err_q,       err_d;

  logic              acc;
  logic [3:0]        in_ready;
  logic [3:0]        req;
  logic [3:0]        push;
  logic [3:0]        pop;
  logic              gnt_onehot;
  logic              gnt_valid;
  logic              gnt_bad;
  logic [1:0]        gnt_idx;

  // Requests are masked by output availability: the arbiter advances on every
  // nonzero grant, so it must never see a request we cannot consume.
  always_comb begin
    acc = !out_valid_q || bus.out_ready;
    for (int i = 0; i < 4; i++) begin
      in_ready[i] = (cnt_q[i] != FULL_CNT);
      req[i]      = (cnt_q[i] != '0) && acc;
    end
  end

  always_comb begin
    gnt_onehot = (bus.gnt != 4'b0000) && ((bus.gnt & (bus.gnt - 4'd1)) == 4'b0000);
    gnt_valid  = gnt_onehot && ((bus.gnt & ~req) == 4'b0000);
    gnt_bad    = (bus.gnt != 4'b0000) && !gnt_valid;
    gnt_idx    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (bus.gnt[i]) gnt_idx = 2'(i);
    end
    push = bus.in_valid & in_ready;
    pop  = gnt_valid ? bus.gnt : 4'b0000;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_ptr_d[i] = rd_ptr_q[i];
      wr_ptr_d[i] = wr_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
      if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
      case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // A malformed grant freezes the output register entirely, even if the
  // downstream side is ready; only the sticky error flag reacts.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    err_d       = err_q | gnt_bad;
    if (gnt_valid) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
      out_src_d   = gnt_idx;
    end else if (!gnt_bad && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]    <= '0;
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 2'd0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]    <= cnt_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
      end
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      err_q       <= err_d;
    end
  end

  // Storage is deliberately left unreset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= bus.in_data[i*DATA_W +: DATA_W];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.req       = req;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_rr_req_queue.sv
// Bench for rr_req_queue: behavioural round-robin arbiter plus a queue-based
// reference model, directed scenarios followed by a randomized phase.
module tb_rr_req_queue;
  localparam int DW = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  rr_req_queue_if #(.DATA_W(DW)) bus ();

  rr_req_queue #(.DATA_W(DW), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment arbiter: rotating priority, pointer moves past each winner.
  logic       force_en;
  logic [3:0] force_gnt;
  logic [3:0] arb_gnt;
  logic [1:0] arb_ptr;
  logic [1:0] arb_j;

  always_comb begin
    arb_gnt = 4'b0000;
    arb_j   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      arb_j = arb_ptr + 2'(k);
      if (arb_gnt == 4'b0000 && bus.req[arb_j]) arb_gnt[arb_j] = 1'b1;
    end
  end

  assign bus.gnt = force_en ? force_gnt : arb_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) arb_ptr <= 2'd0;
    else if (!force_en && arb_gnt != 4'b0000) begin
      for (int k = 0; k < 4; k++) begin
        if (arb_gnt[k]) arb_ptr <= 2'(k + 1);
      end
    end
  end

  // Reference model state
  logic [7:0] mq [4][$];
  logic       m_ov;
  logic [7:0] m_od;
  logic [1:0] m_os;
  logic       m_err;
  int         m_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mq[i].delete();
    m_ov  = 1'b0;
    m_od  = 8'h00;
    m_os  = 2'd0;
    m_err = 1'b0;
    m_ptr = 0;
  endtask

  task automatic set_in(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3);
    bus.in_valid = v;
    bus.in_data  = {d3, d2, d1, d0};
  endtask

  // One clock: compare every output against the model, then advance the model.
  task automatic cycle();
    logic [3:0] ereq, erdy, g, push;
    logic       acc, gv, ordy;
    logic [7:0] din [4];
    int         w;
    #1;
    ordy = bus.out_ready;
    acc  = !m_ov || ordy;
    for (int i = 0; i < 4; i++) begin
      erdy[i] = (mq[i].size() < 4);
      ereq[i] = (mq[i].size() != 0) && acc;
      push[i] = bus.in_valid[i] && erdy[i];
      din[i]  = bus.in_data[i*DW +: DW];
    end
    chk("in_ready",  32'(bus.in_ready),  32'(erdy));
    chk("req",       32'(bus.req),       32'(ereq));
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    chk("out_data",  32'(bus.out_data),  32'(m_od));
    chk("out_src",   32'(bus.out_src),   32'(m_os));
    chk("err",       32'(bus.err),       32'(m_err));
    g = 4'b0000;
    w = -1;
    if (force_en) g = force_gnt;
    else if (acc) begin
      for (int k = 0; k < 4; k++) begin
        if (w < 0 && mq[(m_ptr + k) % 4].size() != 0) w = (m_ptr + k) % 4;
      end
      if (w >= 0) g[w] = 1'b1;
    end
    gv = (g != 4'b0000) && ($countones(g) == 1) && ((g & ~ereq) == 4'b0000);
    @(posedge clk);
    if (gv) begin
      for (int k = 0; k < 4; k++) if (g[k]) w = k;
      m_od = mq[w].pop_front();
      m_os = 2'(w);
      m_ov = 1'b1;
      if (!force_en) m_ptr = (w + 1) % 4;
    end else if (g == 4'b0000 && ordy) begin
      m_ov = 1'b0;
    end
    if (g != 4'b0000 && !gv) m_err = 1'b1;
    for (int i = 0; i < 4; i++) if (push[i]) mq[i].push_back(din[i]);
    @(negedge clk);
  endtask

  // Called just after a falling edge; asserts reset asynchronously mid-cycle.
  task automatic apply_reset();
    bus.in_valid  = 4'b0000;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    force_en      = 1'b0;
    rst_n         = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_req",       32'(bus.req),       32'd0);
    chk("rst_err",       32'(bus.err),       32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'hF);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_src",  32'(bus.out_src),  32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=1000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b1;
    force_en      = 1'b0;
    force_gnt     = 4'b0000;
    bus.in_valid  = 4'b0000;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    model_clear();
    @(negedge clk);
    apply_reset();

    // Single source: push 0xA5 on source 2
    set_in(4'b0100, 8'h00, 8'h00, 8'hA5, 8'h00);
    cycle();
    set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("single_req", 32'(bus.req), 32'h4);
    cycle();
    chk("single_valid", 32'(bus.out_valid), 32'd1);
    chk("single_data",  32'(bus.out_data),  32'hA5);
    chk("single_src",   32'(bus.out_src),   32'd2);
    cycle();

    // Fairness: two entries per source, then drain with out_ready held high
    apply_reset();
    bus.out_ready = 1'b0;
    set_in(4'b1111, 8'h10, 8'h11, 8'h12, 8'h13);
    cycle();
    cycle();
    set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("fair_src",  32'(bus.out_src),  32'(k % 4));
      chk("fair_data", 32'(bus.out_data), 32'(8'h10 + 8'(k % 4)));
      cycle();
    end
    cycle();

    // Full boundary and backpressure: park 0x77 in the output, then overfill source 0
    set_in(4'b0010, 8'h00, 8'h77, 8'h00, 8'h00);
    bus.out_ready = 1'b0;
    cycle();
    set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    cycle();
    for (int j = 0; j < 5; j++) begin
      set_in(4'b0001, 8'(8'h50 + 8'(j)), 8'h00, 8'h00, 8'h00);
      chk("full_in_ready0", 32'(bus.in_ready[0]), 32'(j < 4));
      chk("bp_req",         32'(bus.req),         32'd0);
      chk("bp_data",        32'(bus.out_data),    32'h77);
      chk("bp_src",         32'(bus.out_src),     32'd1);
      cycle();
    end
    set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    bus.out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      cycle();
      chk("drain_valid", 32'(bus.out_valid), 32'd1);
      chk("drain_data",  32'(bus.out_data),  32'(8'h50 + 8'(j)));
      chk("drain_src",   32'(bus.out_src),   32'd0);
    end
    cycle();
    chk("drain_done", 32'(bus.out_valid), 32'd0);

    // Protocol error: multi-hot grant
    apply_reset();
    set_in(4'b0011, 8'h33, 8'h44, 8'h00, 8'h00);
    cycle();
    set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    force_en  = 1'b1;
    force_gnt = 4'b0011;
    cycle();
    force_en = 1'b0;
    chk("err_multi",      32'(bus.err),       32'd1);
    chk("err_multi_hold", 32'(bus.out_valid), 32'd0);
    cycle();
    chk("err_nopop_data", 32'(bus.out_data), 32'h33);
    cycle();
    chk("err_nopop_next", 32'(bus.out_data), 32'h44);
    repeat (3) cycle();
    chk("err_sticky", 32'(bus.err), 32'd1);

    // Protocol error: grant to a non-requesting source; reset must clear err
    apply_reset();
    set_in(4'b0010, 8'h00, 8'h55, 8'h00, 8'h00);
    cycle();
    set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    force_en  = 1'b1;
    force_gnt = 4'b0001;
    cycle();
    force_en = 1'b0;
    chk("err_stray",       32'(bus.err),       32'd1);
    chk("err_stray_hold",  32'(bus.out_valid), 32'd0);
    cycle();
    chk("err_stray_data",  32'(bus.out_data),  32'h55);
    chk("err_stray_src",   32'(bus.out_src),   32'd1);
    cycle();

    // Randomized traffic against the model
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      bus.in_valid = 4'($urandom);
      for (int i = 0; i < 4; i++) bus.in_data[i*DW +: DW] = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Mid-operation reset with queued data and a held output
    apply_reset();
    bus.out_ready = 1'b0;
    set_in(4'b1111, 8'h21, 8'h22, 8'h23, 8'h24);
    cycle();
    set_in(4'b1111, 8'h31, 8'h32, 8'h33, 8'h34);
    cycle();
    set_in(4'b0001, 8'h41, 8'h00, 8'h00, 8'h00);
    cycle();
    chk("midrst_pre_valid", 32'(bus.out_valid), 32'd1);
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("midrst_no_output", 32'(bus.out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
